radix_4_otfc_v1: RTL and testbench

- Receiving end of the radix-4 quotient-digit stream produced by the QDS stage.
- Accepts one one-hot signed digit per cycle from the set {-2, -1, 0, +1, +2}.
- Builds the binary quotient on the fly in two registers: Q, and QM (QM = Q - 1).
- Applies the final remainder-sign correction and presents the result through a valid/ready handshake to the divider's post-processing stage.

---
 rtl/radix_4_otfc_v1.sv | 132 +++++++++++++
 tb/tb_radix_4_otfc_v1.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/radix_4_otfc_v1.sv
// On-the-fly conversion of a radix-4 one-hot signed-digit stream into a binary
// quotient, with final remainder-sign correction and a valid/ready result port.
module radix_4_otfc_v1 #(
    parameter int unsigned WIDTH             = 32,
    parameter int unsigned QUOT_ONEHOT_WIDTH = 5,
    parameter int unsigned MAX_DIGITS        = WIDTH / 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         digit_valid_i,
    input  logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i,
    input  logic                         last_i,
    input  logic                         rem_neg_i,
    output logic                         quot_valid_o,
    input  logic                         quot_ready_i,
    output logic [WIDTH-1:0]             quot_o,
    output logic                         busy_o,
    output logic [$clog2(MAX_DIGITS):0]  digit_cnt_o,
    output logic                         err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   qm_q;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   qm_d;
    logic               bad_digit;
    logic               final_digit;
    logic               load;

    // Next Q/QM for the presented digit; malformed digits behave as zero.
    always_comb begin
        q_d       = {q_q[WIDTH-3:0], 2'b00};
        qm_d      = {qm_q[WIDTH-3:0], 2'b11};
        bad_digit = 1'b0;
        case (quot_digit_i)
            5'b10000: begin
                q_d  = {q_q[WIDTH-3:0], 2'b10};
                qm_d = {q_q[WIDTH-3:0], 2'b01};
            end
            5'b01000: begin
                q_d  = {q_q[WIDTH-3:0], 2'b01};
                qm_d = {q_q[WIDTH-3:0], 2'b00};
            end
            5'b00100: begin
                q_d  = {q_q[WIDTH-3:0], 2'b00};
                qm_d = {qm_q[WIDTH-3:0], 2'b11};
            end
            5'b00010: begin
                q_d  = {qm_q[WIDTH-3:0], 2'b11};
                qm_d = {qm_q[WIDTH-3:0], 2'b10};
            end
            5'b00001: begin
                q_d  = {qm_q[WIDTH-3:0], 2'b10};
                qm_d = {qm_q[WIDTH-3:0], 2'b01};
            end
            default: bad_digit = 1'b1;
        endcase
    end

    // A start is honoured in IDLE and ACC, and in DONE only with the handshake.
    always_comb begin
        load        = 1'b0;
        final_digit = last_i || (digit_cnt_o == CNT_W'(MAX_DIGITS - 1));
        case (state_q)
            IDLE:    load = start_i;
            ACC:     load = start_i;
            DONE:    load = start_i && quot_ready_i;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            q_q          <= '0;
            qm_q         <= '1;
            quot_o       <= '0;
            quot_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            digit_cnt_o  <= '0;
            err_o        <= 1'b0;
        end else if (load) begin
            state_q      <= ACC;
            q_q          <= '0;
            qm_q         <= '1;
            quot_valid_o <= 1'b0;
            busy_o       <= 1'b1;
            digit_cnt_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (digit_valid_i) begin
                        q_q         <= q_d;
                        qm_q        <= qm_d;
                        digit_cnt_o <= digit_cnt_o + CNT_W'(1);
                        if (bad_digit) begin
                            err_o <= 1'b1;
                        end
                        if (final_digit) begin
                            quot_o       <= rem_neg_i ? qm_d : q_d;
                            quot_valid_o <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (quot_ready_i) begin
                        quot_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix_4_otfc_v1.sv
// Directed bench for radix_4_otfc_v1 at WIDTH=8: vector table plus
// hand-written sequences for stall, abort, reset and back-to-back cases.
module tb_radix_4_otfc_v1;

    localparam int unsigned W = 8;

    localparam logic [4:0] D_P2 = 5'b10000;
    localparam logic [4:0] D_P1 = 5'b01000;
    localparam logic [4:0] D_Z  = 5'b00100;
    localparam logic [4:0] D_M1 = 5'b00010;
    localparam logic [4:0] D_M2 = 5'b00001;
    localparam logic [4:0] D_B6 = 5'b00110;
    localparam logic [4:0] D_B0 = 5'b00000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic           digit_valid_i = 1'b0;
    logic [4:0]     quot_digit_i = '0;
    logic           last_i = 1'b0;
    logic           rem_neg_i = 1'b0;
    logic           quot_valid_o;
    logic           quot_ready_i = 1'b0;
    logic [W-1:0]   quot_o;
    logic           busy_o;
    logic [2:0]     digit_cnt_o;
    logic           err_o;

    int checks = 0;
    int errors = 0;

    radix_4_otfc_v1 #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .digit_valid_i(digit_valid_i),
        .quot_digit_i (quot_digit_i),
        .last_i       (last_i),
        .rem_neg_i    (rem_neg_i),
        .quot_valid_o (quot_valid_o),
        .quot_ready_i (quot_ready_i),
        .quot_o       (quot_o),
        .busy_o       (busy_o),
        .digit_cnt_o  (digit_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][4:0] dig;
        int              n;
        bit              use_last;
        bit              rem;
        logic [7:0]      exp_q;
        logic [2:0]      exp_cnt;
        bit              exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [4:0] d, input bit last, input bit rem);
        digit_valid_i = 1'b1;
        quot_digit_i  = d;
        last_i        = last;
        rem_neg_i     = rem;
        @(negedge clk);
        digit_valid_i = 1'b0;
        last_i        = 1'b0;
        rem_neg_i     = 1'b0;
        quot_digit_i  = '0;
    endtask

    task automatic handshake();
        quot_ready_i = 1'b1;
        @(negedge clk);
        quot_ready_i = 1'b0;
        check("valid_after_ready", 32'(quot_valid_o), 32'd0);
        check("busy_after_ready", 32'(busy_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{dig: {D_Z,  D_M1, D_Z,  D_P2}, n: 4, use_last: 1, rem: 0, exp_q: 8'h00, exp_cnt: 3'd0, exp_err: 0};
        // digits are listed dig[0] first: +2,+1,0,-1
        vecs[0].dig[0] = D_P2; vecs[0].dig[1] = D_P1; vecs[0].dig[2] = D_Z; vecs[0].dig[3] = D_M1;
        vecs[0].exp_q = 8'h8F; vecs[0].exp_cnt = 3'd4;
        vecs[1] = vecs[0]; vecs[1].rem = 1; vecs[1].exp_q = 8'h8E;
        vecs[2] = vecs[0]; vecs[2].use_last = 0; vecs[2].exp_q = 8'hE0;
        vecs[2].dig[0] = D_M1; vecs[2].dig[1] = D_P2; vecs[2].dig[2] = D_Z; vecs[2].dig[3] = D_Z;
        vecs[3] = vecs[0]; vecs[3].n = 2; vecs[3].exp_q = 8'h05; vecs[3].exp_cnt = 3'd2;
        vecs[3].dig[0] = D_P1; vecs[3].dig[1] = D_P1;
        vecs[4] = vecs[0]; vecs[4].n = 3; vecs[4].exp_q = 8'h11; vecs[4].exp_cnt = 3'd3; vecs[4].exp_err = 1;
        vecs[4].dig[0] = D_P1; vecs[4].dig[1] = D_B6; vecs[4].dig[2] = D_P1;
        vecs[5] = vecs[0]; vecs[5].use_last = 0; vecs[5].rem = 1; vecs[5].exp_q = 8'h55;
        vecs[5].dig[0] = D_M2; vecs[5].dig[1] = D_M2; vecs[5].dig[2] = D_M2; vecs[5].dig[3] = D_M2;
        vecs[6] = vecs[0]; vecs[6].n = 1; vecs[6].rem = 1; vecs[6].exp_q = 8'hFF; vecs[6].exp_cnt = 3'd1;
        vecs[6].dig[0] = D_Z;
        vecs[7] = vecs[0]; vecs[7].n = 2; vecs[7].exp_q = 8'h02; vecs[7].exp_cnt = 3'd2; vecs[7].exp_err = 1;
        vecs[7].dig[0] = D_B0; vecs[7].dig[1] = D_P2;

        @(negedge clk);
        check("rst_quot", 32'(quot_o), 32'd0);
        check("rst_valid", 32'(quot_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(digit_cnt_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Digits in IDLE are ignored.
        send(D_P1, 1'b1, 1'b0);
        check("idle_cnt", 32'(digit_cnt_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        for (int v = 0; v < 8; v++) begin
            pulse_start();
            check("start_busy", 32'(busy_o), 32'd1);
            check("start_err", 32'(err_o), 32'd0);
            check("start_cnt", 32'(digit_cnt_o), 32'd0);
            for (int i = 0; i < vecs[v].n; i++) begin
                check("valid_early", 32'(quot_valid_o), 32'd0);
                send(vecs[v].dig[i], vecs[v].use_last && (i == vecs[v].n - 1), vecs[v].rem);
            end
            check($sformatf("v%0d_valid", v), 32'(quot_valid_o), 32'd1);
            check($sformatf("v%0d_quot", v), 32'(quot_o), 32'(vecs[v].exp_q));
            check($sformatf("v%0d_cnt", v), 32'(digit_cnt_o), 32'(vecs[v].exp_cnt));
            check($sformatf("v%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
            handshake();
        end

        // Stall in DONE: result held, lone start ignored, digits ignored.
        pulse_start();
        send(D_P1, 1'b0, 1'b0);
        send(D_P1, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            start_i       = (c == 2);
            digit_valid_i = 1'b1;
            quot_digit_i  = D_M2;
            @(negedge clk);
            check("stall_valid", 32'(quot_valid_o), 32'd1);
            check("stall_quot", 32'(quot_o), 32'h05);
            check("stall_cnt", 32'(digit_cnt_o), 32'd2);
        end
        start_i = 1'b0;
        digit_valid_i = 1'b0;
        handshake();

        // Abort in ACC: digit in the restart cycle is dropped.
        pulse_start();
        send(D_P2, 1'b0, 1'b0);
        send(D_P2, 1'b0, 1'b0);
        start_i = 1'b1;
        send(D_M1, 1'b0, 1'b0);
        start_i = 1'b0;
        check("abort_cnt", 32'(digit_cnt_o), 32'd0);
        send(D_P1, 1'b1, 1'b0);
        check("abort_quot", 32'(quot_o), 32'h01);
        check("abort_cnt2", 32'(digit_cnt_o), 32'd1);

        // Back-to-back: start with ready in DONE goes straight to ACC.
        start_i = 1'b1;
        quot_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        quot_ready_i = 1'b0;
        check("b2b_valid", 32'(quot_valid_o), 32'd0);
        check("b2b_busy", 32'(busy_o), 32'd1);
        check("b2b_cnt", 32'(digit_cnt_o), 32'd0);
        send(D_M1, 1'b1, 1'b0);
        check("b2b_quot", 32'(quot_o), 32'hFF);
        check("b2b_valid2", 32'(quot_valid_o), 32'd1);
        handshake();

        // Asynchronous reset mid-operation.
        pulse_start();
        send(D_P2, 1'b0, 1'b0);
        send(D_P2, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_cnt", 32'(digit_cnt_o), 32'd0);
        check("arst_quot", 32'(quot_o), 32'd0);
        check("arst_valid", 32'(quot_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(D_P1, 1'b1, 1'b0);
        send(D_P1, 1'b1, 1'b0);
        check("arst_no_result", 32'(quot_valid_o), 32'd0);
        check("arst_idle", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
